aes_mixcol_engine: RTL

Sequential, parametrised AES MixColumns/InvMixColumns engine operating on a full 128-bit AES state instead of a single column.
- Each transaction selects the direction independently.
- The engine processes COLS_PER_CYCLE columns per clock and returns the result over a valid/ready handshake.
- It sits between SubBytes/ShiftRows and AddRoundKey in the iterative cipher/decipher datapath.

---
 rtl/aes_mixcol_pkg.sv | 42 ++++
 rtl/aes_mixcol_column.sv | 33 +++
 rtl/aes_mixcol_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_mixcol_pkg.sv
// Shared types, constants and GF(2^8) helpers for the MixColumns engine.
// Products are built from xtime and XOR only; no lookup tables.
package aes_mixcol_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef logic [31:0] col_t;

  localparam logic [7:0]  GF_POLY  = 8'h1B;  // x^8 + x^4 + x^3 + x + 1, low byte
  localparam int unsigned NUM_COLS = 4;      // columns in an AES state
  localparam int unsigned COL_W    = 32;     // column c = state[127-32c -: 32]
  localparam int unsigned BYTE_W   = 8;      // row r = column[31-8r -: 8]

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul02(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul03(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_mixcol_column.sv
// Combinational single-column MixColumns / InvMixColumns.
// Ports: col_in  - column, row 0 in bits [31:24]
//        inv     - 0: matrix 02 03 01 01, 1: matrix 0e 0b 0d 09
//        col_out - transformed column, same layout
module aes_mixcol_column
  import aes_mixcol_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [31:0] fwd, bwd;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign fwd = {gmul02(a0) ^ gmul03(a1) ^ a2         ^ a3,
                a0         ^ gmul02(a1) ^ gmul03(a2) ^ a3,
                a0         ^ a1         ^ gmul02(a2) ^ gmul03(a3),
                gmul03(a0) ^ a1         ^ a2         ^ gmul02(a3)};

  assign bwd = {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
                gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
                gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
                gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};

  assign col_out = inv ? bwd : fwd;

endmodule

// File: rtl/aes_mixcol_engine.sv
// Iterative AES MixColumns/InvMixColumns over a full 128-bit state,
// COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Ports: clk, rst (async, active high)
//        in_valid/in_ready/in_state/in_inv  - input transaction
//        in_bypass                          - only with AES_MIXCOL_BYPASS_EN
//        out_valid/out_ready/out_state      - result
//        busy                               - transaction in CALC or DONE
// Optional feature macro: AES_MIXCOL_BYPASS_EN (pass columns through unchanged).
module aes_mixcol_engine
  import aes_mixcol_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
`ifdef AES_MIXCOL_BYPASS_EN
  input  logic         in_bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NG       = NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0]  LAST_GRP = 2'(NG - 1);

  // Column c lives at index NUM_COLS-1-c so the packed vector matches FIPS-197 order.
  col_t [NUM_COLS-1:0] data_q, data_d;
  state_e              state_q, state_d;
  logic [1:0]          grp_q, grp_d;
  logic                inv_q, inv_d;
  logic                in_ready_q, out_valid_q, busy_q;
`ifdef AES_MIXCOL_BYPASS_EN
  logic                bypass_q, bypass_d;
`endif

  logic [1:0] col_idx [COLS_PER_CYCLE];
  col_t       col_cur [COLS_PER_CYCLE];
  col_t       col_mix [COLS_PER_CYCLE];
  col_t       col_new [COLS_PER_CYCLE];

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = 2'(grp_q * COLS_PER_CYCLE + i);
    // ~idx on two bits is 3-idx: column number to packed slot
    assign col_cur[i] = data_q[~col_idx[i]];

    aes_mixcol_column u_column (
      .col_in  (col_cur[i]),
      .inv     (inv_q),
      .col_out (col_mix[i])
    );

`ifdef AES_MIXCOL_BYPASS_EN
    assign col_new[i] = bypass_q ? col_cur[i] : col_mix[i];
`else
    assign col_new[i] = col_mix[i];
`endif
  end

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    data_d   = data_q;
    inv_d    = inv_q;
`ifdef AES_MIXCOL_BYPASS_EN
    bypass_d = bypass_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_state;
          inv_d    = in_inv;
`ifdef AES_MIXCOL_BYPASS_EN
          bypass_d = in_bypass;
`endif
          grp_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          data_d[~col_idx[i]] = col_new[i];
        end
        grp_d = grp_q + 2'd1;
        if (grp_q == LAST_GRP) begin
          grp_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      data_q      <= '0;
      inv_q       <= 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      data_q      <= data_d;
      inv_q       <= inv_d;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
      // Handshake flags decoded from the next state so they are plain flops.
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = data_q;

endmodule
